mem_read_arbiter: RTL and testbench



---
 rtl/mem_read_arbiter_if.sv | 39 +++
 rtl/mem_read_arbiter.sv | 103 ++++++++++
 tb/tb_mem_read_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_read_arbiter_if.sv
// AR/R bundle between the L1 requesters, the read arbiter and the downstream port.
// The slave modport is the arbiter's view; the master modport is everything around it.
interface mem_read_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128,
    parameter int RESP_WIDTH = 4
);
    logic [NUM_REQ-1:0]            req_arvalid;
    logic [NUM_REQ-1:0]            req_arready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr;
    logic [NUM_REQ-1:0]            req_rvalid;
    logic [NUM_REQ-1:0]            req_rready;
    logic [DATA_WIDTH-1:0]         req_rdata;
    logic [RESP_WIDTH-1:0]         req_rresp;

    logic                          m_arvalid;
    logic                          m_arready;
    logic [ADDR_WIDTH-1:0]         m_araddr;
    logic                          m_rvalid;
    logic                          m_rready;
    logic [DATA_WIDTH-1:0]         m_rdata;
    logic [RESP_WIDTH-1:0]         m_rresp;
    logic                          m_rlast;

    modport slave (
        input  req_arvalid, req_araddr, req_rready,
        input  m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
        output req_arready, req_rvalid, req_rdata, req_rresp,
        output m_arvalid, m_araddr, m_rready
    );

    modport master (
        output req_arvalid, req_araddr, req_rready,
        output m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
        input  req_arready, req_rvalid, req_rdata, req_rresp,
        input  m_arvalid, m_araddr, m_rready
    );
endinterface

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one downstream AR/R port among NUM_REQ requesters,
// with exactly one read outstanding at a time.
//
// state | meaning
// IDLE  | scanning requesters from rr_ptr, grant accepted combinationally
// ADDR  | addr_q presented on m_ar*, held until m_arready
// DATA  | R channel routed to owner until the rlast handshake
module mem_read_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128,
    parameter int RESP_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_read_arbiter_if.slave   bus,
    output logic                busy,
    output logic                protocol_err
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                  state, state_d;
    logic [IDX_W-1:0]        owner, owner_d;
    logic [IDX_W-1:0]        rr_ptr, rr_ptr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [IDX_W-1:0]        grant, cand;
    logic                    grant_found;
    logic [NUM_REQ-1:0]      arready_vec, rvalid_vec;
    logic                    rready_fwd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner        <= '0;
            rr_ptr       <= '0;
            addr_q       <= '0;
            protocol_err <= 1'b0;
        end else begin
            state        <= state_d;
            owner        <= owner_d;
            rr_ptr       <= rr_ptr_d;
            addr_q       <= addr_d;
            protocol_err <= bus.m_rvalid && (state != DATA);
        end
    end

    // First valid requester at or after rr_ptr, wrapping
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_found && bus.req_arvalid[cand]) begin
                grant_found = 1'b1;
                grant       = cand;
            end
        end
    end

    always_comb begin
        state_d     = state;
        owner_d     = owner;
        rr_ptr_d    = rr_ptr;
        addr_d      = addr_q;
        arready_vec = '0;
        rvalid_vec  = '0;
        rready_fwd  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    arready_vec[grant] = 1'b1;
                    addr_d  = bus.req_araddr[grant*ADDR_WIDTH +: ADDR_WIDTH];
                    owner_d = grant;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (bus.m_arready) state_d = DATA;
            end
            DATA: begin
                rready_fwd        = bus.req_rready[owner];
                rvalid_vec[owner] = bus.m_rvalid;
                if (bus.m_rvalid && rready_fwd && bus.m_rlast) begin
                    state_d  = IDLE;
                    rr_ptr_d = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_arready = arready_vec;
    assign bus.req_rvalid  = rvalid_vec;
    assign bus.req_rdata   = DATA_WIDTH'(bus.m_rdata);
    assign bus.req_rresp   = RESP_WIDTH'(bus.m_rresp);
    assign bus.m_arvalid   = (state == ADDR);
    assign bus.m_araddr    = addr_q;
    assign bus.m_rready    = rready_fwd;
    assign busy            = (state != IDLE);
endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: inputs driven on the falling edge,
// outputs checked 1 ns later, state advances on the rising edge.
module tb_mem_read_arbiter;
    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int RW = 4;
    localparam logic [DW-1:0] DATA_A = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_DEAD_BEEF;

    logic clk = 1'b0;
    logic rst_n;
    logic busy, protocol_err;
    int   total = 0;
    int   bad   = 0;

    mem_read_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_WIDTH(RW)) bus ();

    mem_read_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_WIDTH(RW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .busy         (busy),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.req_arvalid = '0;
        bus.req_araddr  = '0;
        bus.req_rready  = '0;
        bus.m_arready   = 1'b0;
        bus.m_rvalid    = 1'b0;
        bus.m_rdata     = '0;
        bus.m_rresp     = '0;
        bus.m_rlast     = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #2;
        chk("rst_m_arvalid", bus.m_arvalid, 1'b0);
        chk("rst_m_araddr", bus.m_araddr, 32'h0);
        chk("rst_m_rready", bus.m_rready, 1'b0);
        chk("rst_req_arready", bus.req_arready, 2'b00);
        chk("rst_req_rvalid", bus.req_rvalid, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_protocol_err", protocol_err, 1'b0);
        settle(); settle();
        rst_n = 1'b1;

        // single read from requester 1
        settle();
        bus.req_arvalid = 2'b10;
        bus.req_araddr[1*AW +: AW] = 32'h0000_1040;
        #1;
        chk("single_arready", bus.req_arready, 2'b10);
        chk("single_idle_busy", busy, 1'b0);
        settle();
        bus.req_arvalid = 2'b00;
        #1;
        chk("single_m_arvalid", bus.m_arvalid, 1'b1);
        chk("single_m_araddr", bus.m_araddr, 32'h0000_1040);
        chk("single_addr_arready", bus.req_arready, 2'b00);
        chk("single_addr_busy", busy, 1'b1);
        bus.m_arready = 1'b1;
        settle();
        bus.m_arready  = 1'b0;
        bus.req_rready = 2'b10;
        bus.m_rvalid   = 1'b1;
        bus.m_rdata    = DATA_A;
        bus.m_rresp    = 4'h2;
        bus.m_rlast    = 1'b1;
        #1;
        chk("single_data_arvalid", bus.m_arvalid, 1'b0);
        chk("single_req_rvalid", bus.req_rvalid, 2'b10);
        chk("single_req_rdata", bus.req_rdata, DATA_A);
        chk("single_req_rresp", bus.req_rresp, 4'h2);
        chk("single_m_rready", bus.m_rready, 1'b1);
        settle();
        clear_inputs();
        #1;
        chk("single_back_idle", busy, 1'b0);

        // contention: both request, req0 first, then req1, then req0 again
        bus.req_arvalid = 2'b11;
        bus.req_araddr  = {32'h0000_B000, 32'h0000_A000};
        #1;
        chk("cont_grant0", bus.req_arready, 2'b01);
        settle();
        #1;
        chk("cont_addr0", bus.m_araddr, 32'h0000_A000);
        chk("cont_addr_no_arready", bus.req_arready, 2'b00);
        bus.m_arready = 1'b1;
        settle();
        bus.m_arready  = 1'b0;
        bus.req_rready = 2'b11;
        bus.m_rvalid   = 1'b1;
        bus.m_rlast    = 1'b1;
        #1;
        chk("cont_rvalid0", bus.req_rvalid, 2'b01);
        settle();
        bus.m_rvalid = 1'b0;
        bus.m_rlast  = 1'b0;
        bus.req_araddr[0 +: AW] = 32'h0000_A100;
        #1;
        chk("cont_grant1", bus.req_arready, 2'b10);
        settle();
        #1;
        chk("cont_addr1", bus.m_araddr, 32'h0000_B000);
        bus.m_arready = 1'b1;
        settle();
        bus.m_arready = 1'b0;
        bus.m_rvalid  = 1'b1;
        bus.m_rlast   = 1'b1;
        #1;
        chk("cont_rvalid1", bus.req_rvalid, 2'b10);
        settle();
        bus.m_rvalid = 1'b0;
        bus.m_rlast  = 1'b0;
        #1;
        chk("cont_grant0_again", bus.req_arready, 2'b01);
        settle();
        bus.req_arvalid = 2'b00;
        bus.req_rready  = 2'b00;

        // downstream AR stall for 5 cycles
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_arvalid", bus.m_arvalid, 1'b1);
            chk("stall_araddr", bus.m_araddr, 32'h0000_A100);
            settle();
        end
        bus.m_arready = 1'b1;
        settle();
        bus.m_arready = 1'b0;
        #1;
        chk("stall_data_arvalid", bus.m_arvalid, 1'b0);
        chk("stall_data_busy", busy, 1'b1);

        // owner (req0) holds rready low; non-owner rready high must not leak
        bus.req_rready = 2'b10;
        bus.m_rvalid   = 1'b1;
        bus.m_rlast    = 1'b1;
        bus.m_rdata    = 128'h1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_m_rready", bus.m_rready, 1'b0);
            chk("bp_req_rvalid", bus.req_rvalid, 2'b01);
            chk("bp_busy", busy, 1'b1);
            settle();
        end
        bus.req_rready = 2'b01;
        #1;
        chk("bp_release_rready", bus.m_rready, 1'b1);
        settle();
        clear_inputs();
        #1;
        chk("bp_back_idle", busy, 1'b0);

        // stray R beat while idle
        bus.m_rvalid = 1'b1;
        #1;
        chk("stray_m_rready", bus.m_rready, 1'b0);
        chk("stray_err_before", protocol_err, 1'b0);
        settle();
        bus.m_rvalid = 1'b0;
        #1;
        chk("stray_err_pulse", protocol_err, 1'b1);
        chk("stray_state_idle", busy, 1'b0);
        settle();
        #1;
        chk("stray_err_cleared", protocol_err, 1'b0);

        // rr_ptr is 1 now: req1 alone, then multi-beat, then async reset in DATA
        bus.req_arvalid = 2'b10;
        bus.req_araddr  = {32'h0000_C000, 32'h0};
        #1;
        chk("rst_seq_grant1", bus.req_arready, 2'b10);
        settle();
        bus.req_arvalid = 2'b00;
        bus.m_arready   = 1'b1;
        settle();
        bus.m_arready  = 1'b0;
        bus.req_rready = 2'b10;
        bus.m_rvalid   = 1'b1;
        bus.m_rlast    = 1'b0;
        #1;
        chk("mb_m_rready", bus.m_rready, 1'b1);
        settle();
        #1;
        chk("mb_stays_data", bus.req_rvalid, 2'b10);
        chk("mb_busy", busy, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_m_rready", bus.m_rready, 1'b0);
        chk("arst_req_rvalid", bus.req_rvalid, 2'b00);
        chk("arst_busy", busy, 1'b0);
        clear_inputs();
        settle(); settle();
        rst_n = 1'b1;
        settle();
        bus.req_arvalid = 2'b11;
        #1;
        chk("arst_grant0", bus.req_arready, 2'b01);
        settle();
        clear_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
